// File: rtl/ins_fetch_unit.sv
// rtl/ins_fetch_unit.sv - program counter, instruction register and ROM fetch sequencing
// Captures opcode/operand/immediate bytes from a combinational-read ROM under controller strobes.
module ins_fetch_unit #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PC_en,
    input  logic          pc_in,
    input  logic          im_int,
    input  logic [1:0]    fetch,
    input  logic          rom_ena,
    input  logic          rom_read,
    input  logic          ad_sel,
    input  logic [DW-1:0] rom_data,
    output logic [AW-1:0] rom_addr,
    output logic [3:0]    ins,
    output logic [DW-1:0] operand,
    output logic [DW-1:0] imm,
    output logic [AW-1:0] pc,
    output logic          halted
);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_OPC  = 2'd1,
        F_OPR  = 2'd2
    } fstate_t;

    fstate_t       r_state;
    fstate_t       w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [3:0]    r_ins;
    logic [DW-1:0] r_operand;
    logic [DW-1:0] r_imm;
    logic          r_imm_pend;
    logic          r_halted;

    logic          w_rd_ok;
    logic          w_opc_cap;
    logic          w_opr_cap;
    logic          w_imm_cap;
    logic [3:0]    w_opcode;

    assign w_rd_ok  = rom_ena & rom_read;
    assign w_opcode = rom_data[DW-1:DW-4];

    // A jump on the same cycle suppresses the opcode fetch; halt blocks every capture.
    assign w_opc_cap = (fetch == 2'b01) & w_rd_ok & ~ad_sel & ~pc_in & ~r_halted;
    assign w_opr_cap = (fetch == 2'b10) & w_rd_ok & (r_state == F_OPC) & ~r_halted;
    assign w_imm_cap = w_rd_ok & r_imm_pend & ~im_int & ~w_opc_cap & ~r_halted;

    always_comb begin
        w_state_nxt = r_state;
        if (w_opc_cap) begin
            w_state_nxt = F_OPC;
        end else if (w_opr_cap) begin
            w_state_nxt = F_OPR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (!r_halted) begin
            if (pc_in) begin
                r_pc <= rom_data[AW-1:0];
            end else if (PC_en) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ins     <= 4'b0000;
            r_operand <= '0;
            r_halted  <= 1'b0;
        end else begin
            if (w_opc_cap) begin
                r_ins <= w_opcode;
                if (w_opcode == 4'b1111) begin
                    r_halted <= 1'b1;
                end
            end
            if (w_opr_cap) begin
                r_operand <= rom_data;
            end
        end
    end

    // im_int re-arms the pending immediate even on an opcode-fetch cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imm      <= '0;
            r_imm_pend <= 1'b0;
        end else begin
            if (im_int) begin
                r_imm_pend <= 1'b1;
            end else if (w_opc_cap) begin
                r_imm_pend <= 1'b0;
            end else if (w_imm_cap) begin
                r_imm      <= rom_data;
                r_imm_pend <= 1'b0;
            end
        end
    end

    assign rom_addr = ad_sel ? r_operand[AW-1:0] : r_pc;
    assign ins      = r_ins;
    assign operand  = r_operand;
    assign imm      = r_imm;
    assign pc       = r_pc;
    assign halted   = r_halted;

endmodule

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
- Instruction-supply end of the CPU control interface. Owns the program counter and the instruction register, and drives the 4-bit `ins` opcode consumed by the control FSM.
- Responds to the controller's strobes (PC_en, pc_in, im_int, fetch, rom_ena, rom_read, ad_sel) to capture opcode, operand and immediate bytes from instruction ROM, and to advance or load the PC.
- Sits between the control FSM and an asynchronous (combinational-read) instruction ROM.

Parameters:
- AW, 8, PC / ROM address width; must be <= DW.
- DW, 8, ROM data width; opcode is rom_data[DW-1:DW-4].

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- PC_en  in  1  increment PC at end of cycle.
- pc_in  in  1  load PC from rom_data (jump); has priority over PC_en.
- im_int  in  1  arm immediate capture on the next valid ROM read.
- fetch  in  2  01: opcode fetch; 10: operand fetch; 00/11: none.
- rom_ena  in  1  ROM enable.
- rom_read  in  1  ROM read strobe.
- ad_sel  in  1  0: rom_addr=PC; 1: rom_addr=operand (data address phase).
- rom_data  in  DW  combinational ROM read data for rom_addr.
- rom_addr  out  AW  ROM address.
- ins  out  4  current opcode to the controller.
- operand  out  DW  captured operand / data address byte.
- imm  out  DW  captured immediate byte.
- pc  out  AW  current program counter.
- halted  out  1  sticky; set when HLT (4'b1111) is captured.

Behaviour:
- Reset (rst=1 at clk edge; this overrides all other inputs): pc=0, ins=4'b0000 (NOP), operand=0, imm=0, imm_pend=0, halted=0, FSM=F_IDLE.
- rom_addr is combinational: ad_sel ? operand[AW-1:0] : pc. Define rd_ok = rom_ena & rom_read.
- FSM states: F_IDLE, F_OPC (opcode held), F_OPR (operand held).
- Opcode capture: fetch==01 & rd_ok & !ad_sel & !pc_in, in any state:
  - ins <= rom_data[DW-1:DW-4].
  - FSM -> F_OPC.
  - imm_pend cleared.
- Operand capture: fetch==10 & rd_ok & FSM==F_OPC:
  - operand <= rom_data.
  - FSM -> F_OPR.
  - Further fetch==10 cycles while in F_OPR are ignored; only the first cycle of a fetch==10 run captures.
- fetch==10 while in F_IDLE: ignored; no state change.
- Immediate:
  - im_int=1 sets imm_pend at the clock edge.
  - On the first later cycle with rd_ok & imm_pend & !im_int: imm <= rom_data and imm_pend is cleared.
  - im_int held high keeps imm_pend set without capturing.
- PC update, in priority order:
  1. halted: PC frozen.
  2. pc_in: pc <= rom_data[AW-1:0].
  3. PC_en: pc <= pc+1, wrapping from 2^AW-1 to 0.
  4. Otherwise hold.
- Simultaneous pc_in & PC_en: load wins; no increment.
- Simultaneous fetch==01 & pc_in: no opcode capture; the jump takes precedence.
- halted:
  - Set in the same cycle ins captures 4'b1111.
  - Cleared only by rst.
  - While halted, opcode, operand and imm captures are blocked; ins holds HLT.
- Latency:
  - Captured values are visible on outputs the cycle after the capturing edge.
  - rom_addr follows pc / operand / ad_sel with zero latency.
- Reset mid-operation: any pending capture or immediate is discarded; the first opcode fetch after reset reads address 0.

Test Plan:
- Reset then 4 cycles idle -> pc=0, ins=0000, halted=0, rom_addr=0, operand=0, imm=0.
- ROM[0]=8'h2x, ROM[1]=8'h40. Sequence: fetch=01+rd_ok; then PC_en; then fetch=10+rd_ok for 2 cycles; then PC_en; then ad_sel=1 -> ins=0010, operand=8'h40 (captured once), pc=2, rom_addr=8'h40 while ad_sel=1.
- pc=8'hFF, PC_en=1 for one cycle -> pc=8'h00. Then pc_in=1 & PC_en=1 with rom_data=8'h37 -> pc=8'h37.
- ROM[5]=8'h70 (ADN), ROM[6]=8'h0C. At pc=5: opcode fetch, then im_int=1 & PC_en=1, then rd_ok with im_int=0 -> ins=0111, imm=8'h0C, imm_pend=0, pc=6.
- Opcode fetch with rom_data=8'hF0 -> halted=1, ins=1111. Then PC_en pulses and fetch=01 with rom_data=8'h10 -> pc, ins and operand unchanged. Then rst=1 for one cycle -> all outputs at reset values.
- fetch=10 asserted from F_IDLE with rom_data=8'hAA -> operand stays 0. Then rst asserted while imm_pend=1 -> imm_pend=0 and imm=0 after reset.
